// File: rtl/pe2ddr.sv
// pe2ddr: write-back engine from a PE group accumulation buffer to DDR.
// One store instruction becomes one DDR write burst (address phase, then data phase).
module pe2ddr #(
  parameter int PE_NUM     = 32,
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = $clog2(BUF_DEPTH),
  parameter int BATCH      = 4,
  parameter int RES_W      = 32,
  parameter int DDR_W      = 512,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 8,
  parameter int INST_W     = 64,
  parameter int SEL_W      = $clog2(PE_NUM / 4)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  input  logic [INST_W-1:0]         ins,
  output logic [ADDR_W-1:0]         abuf_rd_addr,
  output logic [SEL_W-1:0]          rd_sel,
  input  logic [4*BATCH*RES_W-1:0]  abuf_rd_data,
  output logic [DDR_ADDR_W-1:0]     ddr_addr,
  output logic [BURST_W-1:0]        ddr_size,
  output logic                      ddr_addr_valid,
  input  logic                      ddr_addr_ready,
  output logic [DDR_W-1:0]          ddr_data,
  output logic                      ddr_valid,
  input  logic                      ddr_ready,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t             r_state;
  logic [BURST_W-1:0] r_nm1;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [BURST_W:0]   r_rd_cnt;
  logic [BURST_W-1:0] r_wr_cnt;
  logic               r_ret_vld;
  logic [DDR_W-1:0]   r_fifo [2];
  logic               r_wp;
  logic               r_rp;
  logic [1:0]         r_occ;

  logic [1:0] w_credit;
  logic       w_issue;
  logic       w_pop;
  logic       w_pop_st;
  logic       w_push;
  logic       w_last;
  logic       w_unused;

  assign w_unused = ^ins[INST_W-1:51];

  // a word returning from the buffer counts against the 2-entry FIFO
  assign w_credit = r_occ + {1'b0, r_ret_vld};
  assign w_issue  = (r_state == S_DATA)
                 && (r_rd_cnt <= {1'b0, r_nm1})
                 && (w_credit < 2'd2);

  // returning word is visible at the head when the FIFO is empty
  assign ddr_valid = (r_occ != 2'd0) || r_ret_vld;
  assign ddr_data  = (r_occ != 2'd0) ? r_fifo[r_rp]
                   : (r_ret_vld ? abuf_rd_data : '0);

  assign w_pop    = ddr_valid && ddr_ready;
  assign w_pop_st = w_pop && (r_occ != 2'd0);
  assign w_push   = r_ret_vld && !(w_pop && (r_occ == 2'd0));
  assign w_last   = w_pop && (r_wr_cnt == r_nm1);

  assign abuf_rd_addr = r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      ins_ready      <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      ddr_addr_valid <= 1'b0;
      ddr_addr       <= '0;
      ddr_size       <= '0;
      rd_sel         <= '0;
      r_nm1          <= '0;
      r_rd_ptr       <= '0;
      r_rd_cnt       <= '0;
      r_wr_cnt       <= '0;
      r_ret_vld      <= 1'b0;
    end else begin
      done      <= 1'b0;
      r_ret_vld <= w_issue;
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
        r_rd_cnt <= r_rd_cnt + (BURST_W+1)'(1);
      end
      if (w_pop)
        r_wr_cnt <= r_wr_cnt + BURST_W'(1);
      unique case (r_state)
        S_IDLE: begin
          if (ins_valid) begin
            ddr_addr       <= ins[0 +: DDR_ADDR_W];
            r_rd_ptr       <= ins[32 +: ADDR_W];
            r_nm1          <= ins[40 +: BURST_W];
            ddr_size       <= ins[40 +: BURST_W];
            rd_sel         <= ins[48 +: SEL_W];
            r_rd_cnt       <= '0;
            r_wr_cnt       <= '0;
            ins_ready      <= 1'b0;
            busy           <= 1'b1;
            ddr_addr_valid <= 1'b1;
            r_state        <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ddr_addr_ready) begin
            ddr_addr_valid <= 1'b0;
            r_state        <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_last) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            ins_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp      <= 1'b0;
      r_rp      <= 1'b0;
      r_occ     <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wp] <= abuf_rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_pop_st)
        r_rp <= ~r_rp;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop_st};
    end
  end

  a_fifo_ovf: assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop_st && (r_occ == 2'd2)));
  a_fifo_occ: assert property (@(posedge clk) disable iff (rst)
    (r_occ != 2'd3));

endmodule

// File: tb/tb_pe2ddr.sv
// Directed bench for pe2ddr: bursts, backpressure, address stall,
// buffer wrap, back-to-back instructions and reset mid-burst.
module tb_pe2ddr;

  logic         clk = 1'b0;
  logic         rst;
  logic         ins_valid;
  logic         ins_ready;
  logic [63:0]  ins;
  logic [7:0]   abuf_rd_addr;
  logic [2:0]   rd_sel;
  logic [511:0] abuf_rd_data;
  logic [31:0]  ddr_addr;
  logic [7:0]   ddr_size;
  logic         ddr_addr_valid;
  logic         ddr_addr_ready;
  logic [511:0] ddr_data;
  logic         ddr_valid;
  logic         ddr_ready;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_bad = 0;

  pe2ddr dut (
    .clk            (clk),
    .rst            (rst),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .abuf_rd_addr   (abuf_rd_addr),
    .rd_sel         (rd_sel),
    .abuf_rd_data   (abuf_rd_data),
    .ddr_addr       (ddr_addr),
    .ddr_size       (ddr_size),
    .ddr_addr_valid (ddr_addr_valid),
    .ddr_addr_ready (ddr_addr_ready),
    .ddr_data       (ddr_data),
    .ddr_valid      (ddr_valid),
    .ddr_ready      (ddr_ready),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // accumulation buffer contents: lane k of group g at address a
  function automatic logic [511:0] word(input logic [2:0] g,
                                        input logic [7:0] a);
    logic [511:0] w;
    for (int k = 0; k < 16; k++)
      w[k*32 +: 32] = {5'd0, g, 8'(k), 8'h3C, a};
    return w;
  endfunction

  always @(posedge clk) abuf_rd_data <= word(rd_sel, abuf_rd_addr);

  task automatic run(input logic [31:0] a, input logic [7:0] st,
                     input logic [7:0] nm1, input logic [2:0] g,
                     input int mode, input int stall, input bit hold,
                     input logic [63:0] nxt, input int abort_at);
    int n, beat, cyc, first_v, max_out, out;
    bit ok, stl;
    logic [511:0] pdata;
    logic [7:0] d;
    n = int'(nm1) + 1;
    ins = {13'd0, g, nm1, st, a};
    ins_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (ins_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      ins_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) ins = nxt;
    else ins_valid = 1'b0;
    ddr_addr_ready = (stall == 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_avalid", ddr_addr_valid, 1);
      chk("stall_addr", ddr_addr, a);
      chk("stall_size", ddr_size, nm1);
      chk("stall_no_rd", abuf_rd_addr, st);
    end
    if (stall > 0) begin
      @(posedge clk);
      #1;
      ddr_addr_ready = 1'b1;
    end
    @(negedge clk);
    chk("avalid", ddr_addr_valid, 1);
    chk("addr", ddr_addr, a);
    chk("size", ddr_size, nm1);
    chk("rd_sel", rd_sel, g);
    chk("busy", busy, 1);
    chk("ins_ready_busy", ins_ready, 0);
    beat = 0;
    cyc = 0;
    first_v = -1;
    max_out = 0;
    stl = 0;
    ok = 0;
    pdata = '0;
    while (cyc < 1000) begin
      @(posedge clk);
      #1;
      ddr_addr_ready = 1'b0;
      ddr_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      cyc++;
      @(negedge clk);
      if (abort_at > 0 && beat == abort_at) begin
        rst = 1'b1;
        ddr_ready = 1'b0;
        #1;
        chk("rst_ins_ready", ins_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_dvalid", ddr_valid, 0);
        chk("rst_avalid", ddr_addr_valid, 0);
        chk("rst_rd_addr", abuf_rd_addr, 0);
        chk("rst_rd_sel", rd_sel, 0);
        chk("rst_ddata", ddr_data, 0);
        return;
      end
      if (beat == n) begin
        chk("done", done, 1);
        chk("done_ins_ready", ins_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_no_extra", ddr_valid, 0);
        chk("done_rd_sel", rd_sel, g);
        ok = 1;
        break;
      end
      if (ddr_valid && first_v < 0) first_v = cyc;
      d = abuf_rd_addr - st;
      out = int'(d) - beat;
      if (out > max_out) max_out = out;
      if (ddr_valid) begin
        if (stl) chk("stable", ddr_data, pdata);
        if (ddr_ready) begin
          chk("data", ddr_data, word(g, st + 8'(beat)));
          beat++;
          stl = 0;
        end else begin
          stl = 1;
          pdata = ddr_data;
        end
      end
    end
    if (!ok) chk("done_timeout", beat, n);
    chk("first_valid_lat", first_v, 2);
    if (mode == 0) chk("no_bubble", cyc, n + 2);
    else chk("max_outstanding", max_out, 2);
    if (!hold) begin
      @(negedge clk);
      chk("done_pulse", done, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    ins_valid = 1'b0;
    ins = '0;
    ddr_addr_ready = 1'b0;
    ddr_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ins_ready", ins_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_avalid", ddr_addr_valid, 0);
    chk("reset_dvalid", ddr_valid, 0);
    chk("reset_rd_addr", abuf_rd_addr, 0);
    chk("reset_rd_sel", rd_sel, 0);
    chk("reset_addr", ddr_addr, 0);
    chk("reset_size", ddr_size, 0);

    run(32'h0000_1000, 8'h10, 8'd3, 3'd2, 0, 0, 0, '0, 0);
    run(32'h2000_0040, 8'h40, 8'd7, 3'd5, 1, 0, 0, '0, 0);
    run(32'hDEAD_BE00, 8'h80, 8'd2, 3'd7, 0, 5, 0, '0, 0);
    run(32'h8000_0000, 8'hFE, 8'd255, 3'd1, 0, 0, 0, '0, 0);

    run(32'h0000_0500, 8'h20, 8'd0, 3'd3, 0, 0, 1,
        {13'd0, 3'd4, 8'd2, 8'h33, 32'h0000_3000}, 0);
    chk("b2b_accept_in_done", {done, ins_ready}, 2'b11);
    run(32'h0000_3000, 8'h33, 8'd2, 3'd4, 0, 0, 0, '0, 0);

    run(32'h0000_4000, 8'h50, 8'd7, 3'd6, 0, 0, 0, '0, 3);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(32'h0000_5000, 8'h60, 8'd1, 3'd0, 0, 0, 0, '0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
